// File: rtl/pll_mon_pkg.sv
// rtl/pll_mon_pkg.sv - state encoding shared by the PLL lock monitor
package pll_mon_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_WAIT_LOCK = 2'd0;
    localparam state_t ST_STABLE    = 2'd1;
    localparam state_t ST_HOLD      = 2'd2;
    localparam state_t ST_RUN       = 2'd3;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - N-stage single-bit synchronizer with async active-low reset
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_monitor.sv
// rtl/pll_lock_monitor.sv - qualifies PLL lock, sequences the clk_div-domain reset, tracks lock losses
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int HOLD_CYCLES   = 8,
    parameter int CNT_W         = 8
) (
    input  logic             clk_div,
    input  logic             sys_rst_n,
    input  logic             locked,
    input  logic             cnt_clr,
    output logic             rst_out_n,
    output logic             ready,
    output logic             unlock_pulse,
    output logic [CNT_W-1:0] lock_lost_cnt,
    output logic [1:0]       state
);

    localparam int CYC_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    localparam logic [CYC_W-1:0] STABLE_LOAD = CYC_W'(STABLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] HOLD_LOAD   = CYC_W'(HOLD_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_ONE     = CYC_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             locked_s;
    state_t           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_out_q, ready_q, pulse_q;
    logic             loss;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_locked (
        .clk_i  (clk_div),
        .rst_ni (sys_rst_n),
        .d_i    (locked),
        .q_o    (locked_s)
    );

    // STABLE and HOLD share one down-counter; each state reloads it on entry.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        loss    = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                    cyc_d   = STABLE_LOAD;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cyc_q == '0) begin
                    state_d = ST_HOLD;
                    cyc_d   = HOLD_LOAD;
                end else begin
                    cyc_d = cyc_q - CYC_ONE;
                end
            end
            ST_HOLD: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cyc_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cyc_d = cyc_q - CYC_ONE;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    loss    = 1'b1;
                end
            end
            default: state_d = ST_WAIT_LOCK;
        endcase
    end

    // A clear that lands on a loss event still records that loss.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = loss ? CNT_ONE : '0;
        end else if (loss && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_div or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_WAIT_LOCK;
            cyc_q     <= '0;
            cnt_q     <= '0;
            rst_out_q <= 1'b0;
            ready_q   <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            cnt_q     <= cnt_d;
            rst_out_q <= (state_d == ST_RUN);
            ready_q   <= (state_d == ST_RUN);
            pulse_q   <= loss;
        end
    end

    assign rst_out_n     = rst_out_q;
    assign ready         = ready_q;
    assign unlock_pulse  = pulse_q;
    assign lock_lost_cnt = cnt_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb/tb_pll_lock_monitor.sv - directed scoreboard bench for pll_lock_monitor
module tb_pll_lock_monitor;
    import pll_mon_pkg::*;

    logic       clk_div = 1'b0;
    logic       sys_rst_n;
    logic       locked;
    logic       cnt_clr;
    logic       rst_out_n;
    logic       ready;
    logic       unlock_pulse;
    logic [1:0] lock_lost_cnt;
    logic [1:0] state;

    always #5 clk_div = ~clk_div;

    pll_lock_monitor #(
        .CNT_W (2)
    ) dut (
        .clk_div       (clk_div),
        .sys_rst_n     (sys_rst_n),
        .locked        (locked),
        .cnt_clr       (cnt_clr),
        .rst_out_n     (rst_out_n),
        .ready         (ready),
        .unlock_pulse  (unlock_pulse),
        .lock_lost_cnt (lock_lost_cnt),
        .state         (state)
    );

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    // Bundle layout: {rst_out_n, ready, unlock_pulse, lock_lost_cnt[1:0], state[1:0]}
    function automatic logic [6:0] mk(input logic r, input logic y, input logic p,
                                      input logic [1:0] c, input logic [1:0] s);
        return {r, y, p, c, s};
    endfunction

    function automatic void push(input string tag, input logic [6:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endfunction

    task automatic check_out();
        exp_t       x;
        logic [6:0] obs;
        obs = {rst_out_n, ready, unlock_pulse, lock_lost_cnt, state};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %b required an expectation", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.exp) else begin
                errors++;
                $error("FAIL %s: observed %b required %b", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_div);
            edge_n++;
        end
        #1;
    endtask

    task automatic to_edge(input int k);
        if (edge_n < k) step(k - edge_n);
    endtask

    // Edge 0 is the first rising edge after release.
    task automatic hold_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(posedge clk_div);
        #2;
        sys_rst_n = 1'b1;
        edge_n    = -1;
    endtask

    initial begin
        logic [1:0] c;
        sys_rst_n = 1'b0;
        locked    = 1'b0;
        cnt_clr   = 1'b0;
        #12;
        push("reset_state", mk(0, 0, 0, 2'd0, ST_WAIT_LOCK));
        check_out();

        // Basic lock
        locked = 1'b1;
        hold_reset();
        push("lock_e1_wait",    mk(0, 0, 0, 2'd0, ST_WAIT_LOCK));
        push("lock_e2_stable",  mk(0, 0, 0, 2'd0, ST_STABLE));
        push("lock_e17_stable", mk(0, 0, 0, 2'd0, ST_STABLE));
        push("lock_e18_hold",   mk(0, 0, 0, 2'd0, ST_HOLD));
        push("lock_e25_hold",   mk(0, 0, 0, 2'd0, ST_HOLD));
        push("lock_e26_run",    mk(1, 1, 0, 2'd0, ST_RUN));
        to_edge(1);  check_out();
        to_edge(2);  check_out();
        to_edge(17); check_out();
        to_edge(18); check_out();
        to_edge(25); check_out();
        to_edge(26); check_out();

        // Loss in RUN: locked drops before edge 40
        to_edge(39);
        locked = 1'b0;
        push("loss_e41_run",   mk(1, 1, 0, 2'd0, ST_RUN));
        push("loss_e42_event", mk(0, 0, 1, 2'd1, ST_WAIT_LOCK));
        push("loss_e43_pulse", mk(0, 0, 0, 2'd1, ST_WAIT_LOCK));
        to_edge(41); check_out();
        to_edge(42); check_out();
        to_edge(43); check_out();

        cnt_clr = 1'b1;
        push("clr_alone", mk(0, 0, 0, 2'd0, ST_WAIT_LOCK));
        step(1);
        cnt_clr = 1'b0;
        check_out();

        // Glitch during STABLE: low for edges 10..12
        locked = 1'b1;
        hold_reset();
        to_edge(9);
        locked = 1'b0;
        push("glitch_e11_stable", mk(0, 0, 0, 2'd0, ST_STABLE));
        push("glitch_e12_wait",   mk(0, 0, 0, 2'd0, ST_WAIT_LOCK));
        push("glitch_e14_wait",   mk(0, 0, 0, 2'd0, ST_WAIT_LOCK));
        push("glitch_e15_stable", mk(0, 0, 0, 2'd0, ST_STABLE));
        push("glitch_e38_hold",   mk(0, 0, 0, 2'd0, ST_HOLD));
        push("glitch_e39_run",    mk(1, 1, 0, 2'd0, ST_RUN));
        to_edge(11); check_out();
        to_edge(12); check_out();
        locked = 1'b1;
        to_edge(14); check_out();
        to_edge(15); check_out();
        to_edge(38); check_out();
        to_edge(39); check_out();

        // Saturation: five loss/relock cycles with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            c = (i >= 2) ? 2'd3 : 2'(i + 1);
            locked = 1'b0;
            push($sformatf("sat_loss_%0d", i),  mk(0, 0, 1, c, ST_WAIT_LOCK));
            push($sformatf("sat_relock_%0d", i), mk(1, 1, 0, c, ST_RUN));
            step(3);
            check_out();
            locked = 1'b1;
            step(27);
            check_out();
        end

        locked = 1'b0;
        push("clr_with_loss", mk(0, 0, 1, 2'd1, ST_WAIT_LOCK));
        step(2);
        cnt_clr = 1'b1;
        step(1);
        cnt_clr = 1'b0;
        check_out();

        // Reset mid-HOLD, asynchronously between clock edges
        locked = 1'b1;
        push("hold_pre_reset", mk(0, 0, 0, 2'd1, ST_HOLD));
        step(21);
        check_out();
        #2;
        sys_rst_n = 1'b0;
        #1;
        push("async_reset", mk(0, 0, 0, 2'd0, ST_WAIT_LOCK));
        check_out();
        hold_reset();
        push("rerun_e25_hold", mk(0, 0, 0, 2'd0, ST_HOLD));
        push("rerun_e26_run",  mk(1, 1, 0, 2'd0, ST_RUN));
        to_edge(25); check_out();
        to_edge(26); check_out();

        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL scoreboard_drained: observed %0d left required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
